// File: rtl/can_pkg.sv
// can_pkg: state encoding, field lengths and DLC helper for the CAN frame
// sequencer. The ID_EXT/RTR_EXT/R1 states exist only with CAN_EXT_FRAME_EN.
package can_pkg;

  localparam int ID_BITS  = 11;
  localparam int EXT_BITS = 18;
  localparam int CRC_BITS = 15;
  localparam int EOF_BITS = 7;
  localparam int IFS_BITS = 3;
  localparam int DLC_BITS = 4;
  localparam int STATE_W  = 5;

  // Each state names the field of the next sampled bit.
  // ID..CRC are kept contiguous so the stuff window is a range test.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 5'd0,
    S_ID      = 5'd2,
    S_RTR     = 5'd3,
    S_IDE     = 5'd4,
`ifdef CAN_EXT_FRAME_EN
    S_ID_EXT  = 5'd5,
    S_RTR_EXT = 5'd6,
    S_R1      = 5'd7,
`endif
    S_R0      = 5'd8,
    S_DLC     = 5'd9,
    S_DATA    = 5'd10,
    S_CRC     = 5'd11,
    S_CRC_DEL = 5'd12,
    S_ACK     = 5'd13,
    S_ACK_DEL = 5'd14,
    S_EOF     = 5'd15,
    S_IFS     = 5'd16,
    S_ERROR   = 5'd17
  } can_field_e;

  // Reload value for the DATA field: 8*min(dlc,max)-1.
  function automatic logic [6:0] data_last(
    input logic [3:0] dlc,
    input int         max_dlc
  );
    logic [3:0] n;
    n = (int'(dlc) > max_dlc) ? 4'(max_dlc) : dlc;
    return {n, 3'b000} - 7'd1;
  endfunction

endpackage

// File: rtl/can_frame_sequencer_if.sv
// can_frame_sequencer_if: destuffed-bit inputs and field strobes.
// master drives SP/RX/STUFF_BIT/EXT_ERROR; slave is the sequencer.
interface can_frame_sequencer_if;

  logic       SP;
  logic       RX;
  logic       STUFF_BIT;
  logic       EXT_ERROR;
  logic       F_CRC_D;
  logic       F_ACK_D;
  logic       F_EOF_D;
  logic       STUFF_EN;
  logic       ACK_SLOT;
  logic       FORM_ERR;
  logic       FRAME_OK;
  logic [3:0] DLC_OUT;
  logic [4:0] STATE;

  modport master (
    output SP, RX, STUFF_BIT, EXT_ERROR,
    input  F_CRC_D, F_ACK_D, F_EOF_D,
    input  STUFF_EN, ACK_SLOT,
    input  FORM_ERR, FRAME_OK,
    input  DLC_OUT, STATE
  );

  modport slave (
    input  SP, RX, STUFF_BIT, EXT_ERROR,
    output F_CRC_D, F_ACK_D, F_EOF_D,
    output STUFF_EN, ACK_SLOT,
    output FORM_ERR, FRAME_OK,
    output DLC_OUT, STATE
  );

endinterface

// File: rtl/can_bus_idle_cnt.sv
// can_bus_idle_cnt: saturating count of consecutive recessive SPs.
// Ports: clock, reset (async low), sp, rx in; idle out (count == IDLE_BITS).
module can_bus_idle_cnt
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic sp,
  input  logic rx,
  output logic idle
);

  localparam logic [3:0] SAT = 4'(IDLE_BITS);

  logic [3:0] cnt_q;

  // Stuff bits count too: they are real bus levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= SAT;
    end else if (sp) begin
      if (!rx)
        cnt_q <= '0;
      else if (cnt_q != SAT)
        cnt_q <= cnt_q + 4'd1;
    end
  end

  assign idle = (cnt_q == SAT);

endmodule

// File: rtl/can_frame_sequencer.sv
// can_frame_sequencer: tracks destuffed bit position in a CAN frame.
// Ports: clock, reset (async low), bus (slave: SP/RX/STUFF_BIT/EXT_ERROR in,
// field strobes, FORM_ERR, FRAME_OK, DLC_OUT, STATE out).
// CAN_EXT_FRAME_EN compiles in the 29-bit identifier path.
module can_frame_sequencer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int MAX_DLC   = 8
) (
  input logic                  clock,
  input logic                  reset,
  can_frame_sequencer_if.slave bus
);

  can_field_e st_q, st_d;
  logic [6:0] cnt_q, cnt_d;
  logic       rtr_q, rtr_d;
  logic [2:0] dsh_q, dsh_d;
  logic [3:0] dlc_q, dlc_d;
  logic       ferr_d, fok_d;
  logic       idle, adv, last;
  logic [3:0] dlc_n;

  can_bus_idle_cnt #(.IDLE_BITS(IDLE_BITS)) u_idle (
    .clock (clock),
    .reset (reset),
    .sp    (bus.SP),
    .rx    (bus.RX),
    .idle  (idle)
  );

  assign adv   = bus.SP & ~bus.STUFF_BIT;
  assign last  = (cnt_q == '0);
  assign dlc_n = {dsh_q, bus.RX};

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rtr_d  = rtr_q;
    dsh_d  = dsh_q;
    dlc_d  = dlc_q;
    ferr_d = 1'b0;
    fok_d  = 1'b0;
    if (st_q == S_ERROR) begin
      if (idle) st_d = S_IDLE;
    end else if (adv) begin
      unique case (st_q)
        // The SOF bit itself is checked here.
        S_IDLE:
          if (!bus.RX && idle) begin
            st_d  = S_ID;
            cnt_d = 7'(ID_BITS - 1);
          end
        S_ID:
          if (last) st_d = S_RTR;
          else cnt_d = cnt_q - 7'd1;
        S_RTR: begin
          rtr_d = bus.RX;
          st_d  = S_IDE;
        end
        S_IDE:
          if (!bus.RX) begin
            st_d = S_R0;
          end else begin
`ifdef CAN_EXT_FRAME_EN
            st_d  = S_ID_EXT;
            cnt_d = 7'(EXT_BITS - 1);
`else
            ferr_d = 1'b1;
`endif
          end
`ifdef CAN_EXT_FRAME_EN
        S_ID_EXT:
          if (last) st_d = S_RTR_EXT;
          else cnt_d = cnt_q - 7'd1;
        S_RTR_EXT: begin
          rtr_d = bus.RX;
          st_d  = S_R1;
        end
        S_R1: st_d = S_R0;
`endif
        S_R0: begin
          ferr_d = bus.RX;
          st_d   = S_DLC;
          cnt_d  = 7'(DLC_BITS - 1);
        end
        S_DLC: begin
          dsh_d = dlc_n[2:0];
          if (last) begin
            dlc_d = dlc_n;
            if (rtr_q || dlc_n == '0) begin
              st_d  = S_CRC;
              cnt_d = 7'(CRC_BITS - 1);
            end else begin
              st_d  = S_DATA;
              cnt_d = data_last(dlc_n, MAX_DLC);
            end
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        S_DATA:
          if (last) begin
            st_d  = S_CRC;
            cnt_d = 7'(CRC_BITS - 1);
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        S_CRC:
          if (last) st_d = S_CRC_DEL;
          else cnt_d = cnt_q - 7'd1;
        S_CRC_DEL: st_d = S_ACK;
        S_ACK:     st_d = S_ACK_DEL;
        S_ACK_DEL: begin
          st_d  = S_EOF;
          cnt_d = 7'(EOF_BITS - 1);
        end
        // No overload frames: a dominant in any EOF bit is a form error.
        S_EOF:
          if (!bus.RX) begin
            ferr_d = 1'b1;
          end else if (last) begin
            fok_d = 1'b1;
            st_d  = S_IFS;
            cnt_d = 7'(IFS_BITS - 1);
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        S_IFS:
          if (last) st_d = S_IDLE;
          else cnt_d = cnt_q - 7'd1;
        default: st_d = S_IDLE;
      endcase
    end
    // Errors win over any advance, stuff bit or not.
    if (st_q != S_IDLE && (bus.EXT_ERROR || ferr_d))
      st_d = S_ERROR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q         <= S_IDLE;
      cnt_q        <= '0;
      rtr_q        <= 1'b0;
      dsh_q        <= '0;
      dlc_q        <= '0;
      bus.F_CRC_D  <= 1'b1;
      bus.F_ACK_D  <= 1'b1;
      bus.F_EOF_D  <= 1'b1;
      bus.STUFF_EN <= 1'b0;
      bus.ACK_SLOT <= 1'b0;
      bus.FORM_ERR <= 1'b0;
      bus.FRAME_OK <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      rtr_q        <= rtr_d;
      dsh_q        <= dsh_d;
      dlc_q        <= dlc_d;
      bus.F_CRC_D  <= (st_d != S_CRC_DEL);
      bus.F_ACK_D  <= (st_d != S_ACK_DEL);
      bus.F_EOF_D  <= (st_d != S_EOF);
      bus.STUFF_EN <= (st_d >= S_ID) &&
                      (st_d <= S_CRC);
      bus.ACK_SLOT <= (st_d == S_ACK);
      bus.FORM_ERR <= ferr_d;
      bus.FRAME_OK <= fok_d;
    end
  end

  assign bus.DLC_OUT = dlc_q;
  assign bus.STATE   = st_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// tb_can_frame_sequencer: directed frames with a scoreboard of expected
// strobe/pulse events keyed by SP index; a monitor pops and compares.
module tb_can_frame_sequencer;
  import can_pkg::*;

  localparam int K_CRCF = 0;
  localparam int K_CRCR = 1;
  localparam int K_ACKF = 2;
  localparam int K_OK   = 3;
  localparam int K_FERR = 4;
  localparam int ST_ERR = 17;

  typedef struct {
    int kind;
    int sp;
    int dlc;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  can_frame_sequencer_if bus();

  can_frame_sequencer #(
    .IDLE_BITS (11),
    .MAX_DLC   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ev_t  exp_q[$];
  logic fb[$];
  logic fs[$];
  int   nsp    = 0;
  int   checks = 0;
  int   passed = 0;
  logic p_crc  = 1'b1;
  logic p_ack  = 1'b1;

  function automatic string kname(input int k);
    case (k)
      K_CRCF:  return "crc_del_fall";
      K_CRCR:  return "crc_del_rise";
      K_ACKF:  return "ack_del_fall";
      K_OK:    return "frame_ok";
      default: return "form_err";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_crc_d"}, int'(bus.F_CRC_D), 1);
    chk({tag, "_ack_d"}, int'(bus.F_ACK_D), 1);
    chk({tag, "_eof_d"}, int'(bus.F_EOF_D), 1);
    chk({tag, "_stuff_en"}, int'(bus.STUFF_EN), 0);
    chk({tag, "_ack_slot"}, int'(bus.ACK_SLOT), 0);
    chk({tag, "_form_err"}, int'(bus.FORM_ERR), 0);
    chk({tag, "_frame_ok"}, int'(bus.FRAME_OK), 0);
    chk({tag, "_dlc"}, int'(bus.DLC_OUT), 0);
    chk({tag, "_state"}, int'(bus.STATE), 0);
  endtask

  task automatic ex(input int k, input int sp, input int dlc = 0);
    ev_t e;
    e.kind = k;
    e.sp   = sp;
    e.dlc  = dlc;
    exp_q.push_back(e);
  endtask

  // Standard-frame offsets from SOF: last CRC bit = 33 + data bits,
  // CRC_DEL +1, ACK +2, EOF bit 7 +10.
  task automatic ex_std(input int b, input int nd, input int dlc);
    ex(K_CRCF, b + 33 + nd);
    ex(K_CRCR, b + 34 + nd);
    ex(K_ACKF, b + 35 + nd);
    ex(K_OK,   b + 43 + nd, dlc);
  endtask

  task automatic observe(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected %s at sp %0d", kname(k), nsp);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.sp == nsp &&
          (k != K_OK || e.dlc == int'(bus.DLC_OUT)))
        passed++;
      else
        $display("FAIL event: got %s sp %0d dlc %0d, expected %s sp %0d dlc %0d",
                 kname(k), nsp, bus.DLC_OUT, kname(e.kind), e.sp, e.dlc);
    end
  endtask

  always @(posedge clock) begin
    #2;
    if (reset) begin
      if (p_crc && !bus.F_CRC_D) observe(K_CRCF);
      if (!p_crc && bus.F_CRC_D) observe(K_CRCR);
      if (p_ack && !bus.F_ACK_D) observe(K_ACKF);
      if (bus.FRAME_OK) observe(K_OK);
      if (bus.FORM_ERR) observe(K_FERR);
    end
    p_crc = bus.F_CRC_D;
    p_ack = bus.F_ACK_D;
  end

  task automatic put(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      fb.push_back(v[i]);
      fs.push_back(1'b0);
    end
  endtask

  task automatic put_stuff(input logic rx);
    fb.push_back(rx);
    fs.push_back(1'b1);
  endtask

  task automatic drive(input logic rx, input logic st);
    @(negedge clock);
    bus.SP = 1'b1;
    bus.RX = rx;
    bus.STUFF_BIT = st;
    @(negedge clock);
    bus.SP = 1'b0;
    bus.STUFF_BIT = 1'b0;
    bus.RX = 1'b1;
    nsp++;
  endtask

  task automatic send(input int n);
    int m;
    m = (n < 0 || n > fb.size()) ? fb.size() : n;
    for (int i = 0; i < m; i++) drive(fb[i], fs[i]);
    fb.delete();
    fs.delete();
  endtask

  task automatic hdr_std(input logic [10:0] id, input logic rtr,
                         input logic [3:0] dlc);
    put(0, 1);
    put(32'(id), 11);
    put(32'(rtr), 1);
    put(0, 1);
    put(0, 1);
    put(32'(dlc), 4);
  endtask

  task automatic tail(input int nbytes);
    for (int i = 0; i < nbytes; i++)
      put((i % 2) ? 32'h5A : 32'hA5, 8);
    put(32'h4CD5, 15);
    put(1, 1);
    put(0, 1);
    put(1, 1);
    put(32'h7F, 7);
    put(32'h7, 3);
  endtask

  task automatic recover(input string tag);
    repeat (11) drive(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    chk({tag, "_idle"}, int'(bus.STATE), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    logic [28:0] xid;
    bus.SP = 1'b0;
    bus.RX = 1'b1;
    bus.STUFF_BIT = 1'b0;
    bus.EXT_ERROR = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset("rst");
    reset = 1'b1;
    @(negedge clock);

    // Standard frame ID 0x123, DLC 2, data A5 5A.
    b = nsp;
    ex(K_CRCF, b + 49);
    ex(K_CRCR, b + 50);
    ex(K_ACKF, b + 51);
    ex(K_OK,   b + 59, 2);
    hdr_std(11'h123, 1'b0, 4'd2);
    tail(2);
    send(-1);
    chk("after_frame_idle", int'(bus.STATE), 0);

    // Remote frame: DLC 2 but no DATA field.
    b = nsp;
    ex_std(b, 0, 2);
    hdr_std(11'h2AA, 1'b1, 4'd2);
    tail(0);
    send(-1);

    // DLC 15 clamps to 64 data bits.
    b = nsp;
    ex_std(b, 64, 15);
    hdr_std(11'h7F0, 1'b0, 4'd15);
    tail(8);
    send(-1);

    // DLC 0, dominant EOF bit 4 (frame index 40).
    b = nsp;
    ex(K_CRCF, b + 33);
    ex(K_CRCR, b + 34);
    ex(K_ACKF, b + 35);
    ex(K_FERR, b + 40);
    hdr_std(11'h055, 1'b0, 4'd0);
    tail(0);
    fb[40] = 1'b0;
    send(41);
    @(negedge clock);
    chk("eof_err_state", int'(bus.STATE), ST_ERR);
    repeat (10) drive(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    chk("err_after_10", int'(bus.STATE), ST_ERR);
    drive(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    chk("err_after_11", int'(bus.STATE), 0);
    b = nsp;
    ex_std(b, 16, 2);
    hdr_std(11'h123, 1'b0, 4'd2);
    tail(2);
    send(-1);

    // Stuff bits after ID bit 5 and DLC bit 2 shift events by 2 SPs.
    b = nsp;
    ex(K_CRCF, b + 51);
    ex(K_CRCR, b + 52);
    ex(K_ACKF, b + 53);
    ex(K_OK,   b + 61, 2);
    put(0, 1);
    put(32'h04, 5);
    put_stuff(1'b1);
    put(32'h23, 6);
    put(0, 1);
    put(0, 1);
    put(0, 1);
    put(0, 2);
    put_stuff(1'b1);
    put(32'h2, 2);
    tail(2);
    send(-1);

    // EXT_ERROR on a stuff-bit SP in DATA still enters ERROR.
    hdr_std(11'h123, 1'b0, 4'd2);
    tail(2);
    send(20);
    @(negedge clock);
    bus.SP = 1'b1;
    bus.RX = 1'b1;
    bus.STUFF_BIT = 1'b1;
    bus.EXT_ERROR = 1'b1;
    @(negedge clock);
    bus.SP = 1'b0;
    bus.STUFF_BIT = 1'b0;
    bus.EXT_ERROR = 1'b0;
    nsp++;
    chk("ext_err_state", int'(bus.STATE), ST_ERR);
    recover("ext_err");

    // Reset asserted during DATA bit 10 (frame index 28).
    hdr_std(11'h123, 1'b0, 4'd3);
    tail(2);
    send(28);
    chk("data_stuff_en", int'(bus.STUFF_EN), 1);
    chk("data_dlc", int'(bus.DLC_OUT), 3);
    @(negedge clock);
    bus.SP = 1'b1;
    bus.RX = 1'b1;
    #1 reset = 1'b0;
    #1 chk_reset("mid");
    @(negedge clock);
    bus.SP = 1'b0;
    nsp++;
    reset = 1'b1;
    b = nsp;
    ex_std(b, 16, 2);
    hdr_std(11'h123, 1'b0, 4'd2);
    tail(2);
    send(-1);

    // Extended frame ID 0x1ABCDEF0, DLC 1.
    xid = 29'h1ABCDEF0;
    b = nsp;
    put(0, 1);
    put(32'(xid[28:18]), 11);
    put(1, 1);
    put(1, 1);
    put(32'(xid[17:0]), 18);
    put(0, 1);
    put(0, 1);
    put(0, 1);
    put(1, 4);
    tail(1);
`ifdef CAN_EXT_FRAME_EN
    ex(K_CRCF, b + 61);
    ex(K_CRCR, b + 62);
    ex(K_ACKF, b + 63);
    ex(K_OK,   b + 71, 1);
    send(-1);
`else
    ex(K_FERR, b + 13);
    send(14);
    @(negedge clock);
    chk("ide_err_state", int'(bus.STATE), ST_ERR);
    recover("ide_err");
`endif

    repeat (5) @(negedge clock);
    chk("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/can_frame_sequencer.md
# can_frame_sequencer

Frame-field sequencer for the CAN decoder receive path. It tracks the position of each destuffed bit within a CAN frame and drives the active-low field strobes that sequence the form-error checker (`F_CRC_D`, `F_ACK_D`, `F_EOF_D`). It also gates stuff-rule checking, checks the fixed-form bits it owns (SOF, r0, EOF), and recovers the receiver to idle after an error. It sits between the bit-timing/destuff stage and the error-check blocks.

## Interface
Parameters:
- `IDLE_BITS`, default 11: consecutive recessive bits required before the block treats the bus as idle.
- `MAX_DLC`, default 8: payload bytes; any DLC above this is clamped to it.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `SP`  in  1: sample-point strobe, one `clock` cycle wide.
- `RX`  in  1: sampled bus bit (0 = dominant).
- `STUFF_BIT`  in  1: the current SP carries a stuff bit; the block does not advance.
- `EXT_ERROR`  in  1: pulse from the stuff/CRC/form/ACK checkers that forces the ERROR state.
- `F_CRC_D`  out  1: low while the CRC delimiter is the next sampled bit.
- `F_ACK_D`  out  1: low while the ACK delimiter is the next sampled bit.
- `F_EOF_D`  out  1: low during the EOF bits.
- `STUFF_EN`  out  1: high from SOF through the last CRC bit.
- `ACK_SLOT`  out  1: high during the ACK slot.
- `FORM_ERR`  out  1: one-cycle pulse on an internal form violation.
- `FRAME_OK`  out  1: one-cycle pulse at the end of a complete EOF.
- `DLC_OUT`  out  4: latched raw DLC.
- `STATE`  out  5: current state encoding, for debug.

## Operation
- State advances only on `clock` edges where `SP`=1 and `STUFF_BIT`=0. On a stuff bit (`STUFF_BIT`=1), no state or counter changes.
- Bus-activity counter: this 4-bit counter updates on every `SP`, including stuff bits.
  - It counts consecutive recessive bits and saturates at `IDLE_BITS`.
  - Any dominant bit clears it.
- States and transitions:
  - IDLE → SOF-check: taken on `RX`=0, but only when the bus-activity counter equals `IDLE_BITS`.
  - ID: 11 bits.
  - RTR/SRR: latch the RTR bit.
  - IDE: `RX`=1 → ID_EXT; `RX`=0 → R0.
  - ID_EXT: 18 bits.
  - RTR_EXT: latch the RTR bit.
  - R1.
  - R0: must be dominant, otherwise a form error.
  - DLC: 4 bits, MSB first.
  - DATA: 8×min(DLC, `MAX_DLC`) bits. DATA is skipped when RTR=1 or DLC=0.
  - CRC: 15 bits.
  - CRC_DEL.
  - ACK.
  - ACK_DEL.
  - EOF: 7 bits.
  - IFS: 3 bits, then IDLE.
  - ERROR.
- Form checks owned by this block:
  - A recessive R0 produces `FORM_ERR`.
  - A dominant bit in any of the 7 EOF bits produces `FORM_ERR`.
  - A dominant bit in EOF bit 7 is also a form error (no overload handling).
- Error handling: a form error or `EXT_ERROR`=1 on any cycle, from any non-IDLE state, sends the block to ERROR. ERROR → IDLE once the bus-activity counter reaches `IDLE_BITS`.
- Field bit counter: 7 bits, reloaded on each field entry, counts down to 0. The maximum count is 63 (DATA).
- `FRAME_OK` pulses on the SP that completes EOF bit 7 recessive.

## Timing
- All outputs are registered.
- Strobes change on the `clock` after the qualifying SP, so they are stable before the next SP. Example: `F_CRC_D` falls one clock after the last CRC bit's SP and rises one clock after the CRC_DEL SP.
- Reset values: `F_CRC_D`=`F_ACK_D`=`F_EOF_D`=1, `STUFF_EN`=`ACK_SLOT`=`FORM_ERR`=`FRAME_OK`=0, `DLC_OUT`=0, state IDLE, bus-activity counter=`IDLE_BITS`.
- Simultaneous events:
  - `EXT_ERROR` has priority over an internal advance.
  - `EXT_ERROR` together with a `STUFF_BIT` SP still enters ERROR.
- If `reset` is asserted mid-frame, all state clears immediately (asynchronous). After release the block waits for IDLE→SOF; the counter reset value allows an immediate SOF.
- An SP arriving on consecutive clocks is legal; each SP is processed.

## Configuration
- `CAN_EXT_FRAME_EN` defined: the IDE, ID_EXT, RTR_EXT and R1 path is compiled in, and 29-bit identifiers are sequenced.
- `CAN_EXT_FRAME_EN` undefined: IDE=1 produces `FORM_ERR` and enters ERROR. The ID_EXT, RTR_EXT and R1 states are not present.

## Structure
- Package `can_pkg`:
  - state enum `can_field_e`.
  - field-length constants (`ID_BITS`=11, `EXT_BITS`=18, `CRC_BITS`=15, `EOF_BITS`=7, `IFS_BITS`=3).
  - `STATE` encoding.
- One sub-module, `can_bus_idle_cnt`: the saturating recessive-bit counter, with outputs `idle`.

## Test plan
- Standard data frame, ID 0x123, DLC 2, data 0xA5 0x5A, all delimiters recessive:
  - `F_CRC_D` low for exactly one bit period after CRC bit 15.
  - `F_ACK_D` low after the ACK slot.
  - `FRAME_OK` pulses once; `DLC_OUT`=2.
- DLC=15, RTR=0: exactly 64 DATA bits are sequenced, then CRC; `DLC_OUT`=15.
- Dominant EOF bit 4 → `FORM_ERR` pulse and state ERROR. After 11 recessive SPs → IDLE. A subsequent frame then completes with `FRAME_OK`.
- Stuff bits inserted after ID bit 5 and DLC bit 2 (`STUFF_BIT`=1): field boundaries are unchanged and `F_CRC_D` timing is identical to the unstuffed frame.
- `reset` low during DATA bit 10 → all outputs at their reset values within the same cycle, and the next SOF is accepted.
- Extended frame, ID 0x1ABCDEF0, DLC 1:
  - With `CAN_EXT_FRAME_EN`: `FRAME_OK` pulses.
  - Without `CAN_EXT_FRAME_EN`: `FORM_ERR` on the IDE SP.
